// File: rtl/cu_pkg.sv
// Shared encodings for the ALU system control unit: FSM states, instruction classes,
// datapath select/function codes and the registered control bundle.
package cu_pkg;

    typedef enum logic [2:0] {
        StReset,
        StInit,
        StFetchL,
        StFetchH,
        StDecode,
        StExec,
        StHalt
    } state_e;

    typedef enum logic [1:0] {
        ClsAlu  = 2'b00,
        ClsLdi  = 2'b01,
        ClsJmp  = 2'b10,
        ClsHalt = 2'b11
    } iclass_e;

    // RF and ARF share one function-select encoding.
    localparam logic [2:0] FunHold  = 3'b000;
    localparam logic [2:0] FunInc   = 3'b001;
    localparam logic [2:0] FunLoad  = 3'b010;
    localparam logic [2:0] FunClear = 3'b011;

    localparam logic [3:0] RegR1      = 4'b1000;
    localparam logic [3:0] RegR2      = 4'b0100;
    localparam logic [3:0] RegR3      = 4'b0010;
    localparam logic [3:0] RegR4      = 4'b0001;
    localparam logic [3:0] RfRegNone  = 4'b0000;
    localparam logic [2:0] ArfPc      = 3'b100;
    localparam logic [2:0] ArfAr      = 3'b010;
    localparam logic [2:0] ArfSp      = 3'b001;
    localparam logic [2:0] ArfRegNone = 3'b000;

    localparam logic [1:0] ArfOutPc = 2'b01;
    localparam logic [1:0] ArfOutAr = 2'b10;
    localparam logic [1:0] ArfOutSp = 2'b11;

    // Memory chip select is active low.
    localparam logic MemCsEnable  = 1'b0;
    localparam logic MemCsDisable = 1'b1;
    localparam logic MemWrRead    = 1'b0;
    localparam logic MemWrWrite   = 1'b1;

    localparam logic [1:0] MuxAAlu = 2'b00;
    localparam logic [1:0] MuxAArf = 2'b01;
    localparam logic [1:0] MuxAMem = 2'b10;
    localparam logic [1:0] MuxAImm = 2'b11;
    localparam logic [1:0] MuxBAlu = 2'b00;
    localparam logic [1:0] MuxBArf = 2'b01;
    localparam logic [1:0] MuxBMem = 2'b10;
    localparam logic [1:0] MuxBImm = 2'b11;

    typedef struct packed {
        logic [2:0] rf_out_a_sel;
        logic [2:0] rf_out_b_sel;
        logic [2:0] rf_fun_sel;
        logic [3:0] rf_reg_sel;
        logic [3:0] rf_scr_sel;
        logic [4:0] alu_fun_sel;
        logic       alu_wf;
        logic [1:0] arf_out_c_sel;
        logic [1:0] arf_out_d_sel;
        logic [2:0] arf_fun_sel;
        logic [2:0] arf_reg_sel;
        logic       ir_lh;
        logic       ir_write;
        logic       mem_wr;
        logic       mem_cs;
        logic       mux_c_sel;
        logic [1:0] mux_a_sel;
        logic [1:0] mux_b_sel;
    } ctrl_t;

    function automatic ctrl_t idle_ctrl();
        ctrl_t c;
        c             = '0;
        c.rf_fun_sel  = FunHold;
        c.rf_reg_sel  = RfRegNone;
        c.rf_scr_sel  = RfRegNone;
        c.arf_fun_sel = FunHold;
        c.arf_reg_sel = ArfRegNone;
        c.mem_wr      = MemWrRead;
        c.mem_cs      = MemCsDisable;
        return c;
    endfunction

    function automatic ctrl_t fetch_ctrl(input logic lh);
        ctrl_t c;
        c               = idle_ctrl();
        c.arf_out_d_sel = ArfOutPc;
        c.mem_cs        = MemCsEnable;
        c.mem_wr        = MemWrRead;
        c.ir_write      = 1'b1;
        c.ir_lh         = lh;
        c.arf_fun_sel   = FunInc;
        c.arf_reg_sel   = ArfPc;
        return c;
    endfunction

    function automatic logic [3:0] rf_onehot(input logic [1:0] idx);
        logic [3:0] sel;
        unique case (idx)
            2'd0:    sel = RegR1;
            2'd1:    sel = RegR2;
            2'd2:    sel = RegR3;
            default: sel = RegR4;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/alu_system_control_unit_if.sv
// Control/status bundle between the control unit (master) and the ALU system datapath (slave).
interface alu_system_control_unit_if;
    logic [15:0] IROut;
    logic [3:0]  ALU_Flags;
    logic [2:0]  RF_OutASel;
    logic [2:0]  RF_OutBSel;
    logic [2:0]  RF_FunSel;
    logic [3:0]  RF_RegSel;
    logic [3:0]  RF_ScrSel;
    logic [4:0]  ALU_FunSel;
    logic        ALU_WF;
    logic [1:0]  ARF_OutCSel;
    logic [1:0]  ARF_OutDSel;
    logic [2:0]  ARF_FunSel;
    logic [2:0]  ARF_RegSel;
    logic        IR_LH;
    logic        IR_Write;
    logic        Mem_WR;
    logic        Mem_CS;
    logic        MuxCSel;
    logic [1:0]  MuxASel;
    logic [1:0]  MuxBSel;
    logic        Halted;

    modport master (
        input  IROut, ALU_Flags,
        output RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel, ALU_FunSel, ALU_WF,
               ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel, IR_LH, IR_Write, Mem_WR,
               Mem_CS, MuxCSel, MuxASel, MuxBSel, Halted
    );

    modport slave (
        output IROut, ALU_Flags,
        input  RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel, ALU_FunSel, ALU_WF,
               ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel, IR_LH, IR_Write, Mem_WR,
               Mem_CS, MuxCSel, MuxASel, MuxBSel, Halted
    );
endinterface

// File: rtl/cu_decoder.sv
// Combinational IR -> EXEC-cycle control bundle. CU_COND_JUMP_EN makes class-10 jumps with
// IR[13]=1 conditional on the Z flag.
module cu_decoder
    import cu_pkg::*;
(
    input  logic [15:0] i_ir,
    input  logic [3:0]  i_flags,
    output ctrl_t       o_exec,
    output logic        o_is_halt
);

    logic w_take;
    logic w_unused_bits;

    assign w_unused_bits = ^{i_ir[1:0], i_flags};
    assign o_is_halt     = (iclass_e'(i_ir[15:14]) == ClsHalt);

    always_comb begin
        o_exec = idle_ctrl();
        w_take = 1'b0;
        unique case (iclass_e'(i_ir[15:14]))
            ClsAlu: begin
                o_exec.rf_out_a_sel = {1'b0, i_ir[5:4]};
                o_exec.rf_out_b_sel = {1'b0, i_ir[3:2]};
                o_exec.alu_fun_sel  = i_ir[13:9];
                o_exec.alu_wf       = i_ir[8];
                o_exec.mux_a_sel    = MuxAAlu;
                o_exec.rf_fun_sel   = FunLoad;
                o_exec.rf_reg_sel   = rf_onehot(i_ir[7:6]);
            end
            ClsLdi: begin
                o_exec.mux_a_sel  = MuxAImm;
                o_exec.rf_fun_sel = FunLoad;
                o_exec.rf_reg_sel = rf_onehot(i_ir[9:8]);
            end
            ClsJmp: begin
`ifdef CU_COND_JUMP_EN
                w_take = !i_ir[13] || i_flags[3];
`else
                w_take = 1'b1;
`endif
                if (w_take) begin
                    o_exec.mux_b_sel   = MuxBImm;
                    o_exec.arf_fun_sel = FunLoad;
                    o_exec.arf_reg_sel = ArfPc;
                end
            end
            ClsHalt: begin
            end
        endcase
    end

endmodule

// File: rtl/alu_system_control_unit.sv
// Hardwired fetch/decode/execute sequencer driving every ALU system control strobe.
// Optional conditional jumps are enabled with CU_COND_JUMP_EN (see cu_decoder).
module alu_system_control_unit
    import cu_pkg::*;
(
    input  logic                       i_clk,
    input  logic                       i_rst,
    alu_system_control_unit_if.master  cu_bus
);

    state_e r_state;
    ctrl_t  r_ctrl;
    logic   r_halted;
    ctrl_t  w_exec;
    logic   w_is_halt;

    cu_decoder u_decoder (
        .i_ir      (cu_bus.IROut),
        .i_flags   (cu_bus.ALU_Flags),
        .o_exec    (w_exec),
        .o_is_halt (w_is_halt)
    );

    // Outputs are registered alongside the state: each transition loads the vector of the
    // state being entered, so the bundle always matches r_state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= StReset;
            r_ctrl   <= idle_ctrl();
            r_halted <= 1'b0;
        end else begin
            r_ctrl   <= idle_ctrl();
            r_halted <= 1'b0;
            case (r_state)
                StReset: begin
                    r_state            <= StInit;
                    r_ctrl.arf_fun_sel <= FunClear;
                    r_ctrl.arf_reg_sel <= ArfPc;
                end
                StInit, StExec: begin
                    r_state <= StFetchL;
                    r_ctrl  <= fetch_ctrl(1'b0);
                end
                StFetchL: begin
                    r_state <= StFetchH;
                    r_ctrl  <= fetch_ctrl(1'b1);
                end
                StFetchH: r_state <= StDecode;
                StDecode: begin
                    if (w_is_halt) begin
                        r_state  <= StHalt;
                        r_halted <= 1'b1;
                    end else begin
                        r_state <= StExec;
                        r_ctrl  <= w_exec;
                    end
                end
                StHalt: begin
                    r_state  <= StHalt;
                    r_halted <= 1'b1;
                end
                default: r_state <= StReset;
            endcase
        end
    end

    assign cu_bus.RF_OutASel  = r_ctrl.rf_out_a_sel;
    assign cu_bus.RF_OutBSel  = r_ctrl.rf_out_b_sel;
    assign cu_bus.RF_FunSel   = r_ctrl.rf_fun_sel;
    assign cu_bus.RF_RegSel   = r_ctrl.rf_reg_sel;
    assign cu_bus.RF_ScrSel   = r_ctrl.rf_scr_sel;
    assign cu_bus.ALU_FunSel  = r_ctrl.alu_fun_sel;
    assign cu_bus.ALU_WF      = r_ctrl.alu_wf;
    assign cu_bus.ARF_OutCSel = r_ctrl.arf_out_c_sel;
    assign cu_bus.ARF_OutDSel = r_ctrl.arf_out_d_sel;
    assign cu_bus.ARF_FunSel  = r_ctrl.arf_fun_sel;
    assign cu_bus.ARF_RegSel  = r_ctrl.arf_reg_sel;
    assign cu_bus.IR_LH       = r_ctrl.ir_lh;
    assign cu_bus.IR_Write    = r_ctrl.ir_write;
    assign cu_bus.Mem_WR      = r_ctrl.mem_wr;
    assign cu_bus.Mem_CS      = r_ctrl.mem_cs;
    assign cu_bus.MuxCSel     = r_ctrl.mux_c_sel;
    assign cu_bus.MuxASel     = r_ctrl.mux_a_sel;
    assign cu_bus.MuxBSel     = r_ctrl.mux_b_sel;
    assign cu_bus.Halted      = r_halted;

endmodule

// File: tb/tb_alu_system_control_unit.sv
// Bench: a behavioural datapath reacts to the control unit's strobes while an
// instruction-level model predicts per-cycle controls, PC and register contents.
module tb_alu_system_control_unit;
    import cu_pkg::*;

    typedef struct packed {
        logic [2:0] out_a;
        logic [2:0] out_b;
        logic [2:0] rf_fun;
        logic [3:0] rf_reg;
        logic [3:0] rf_scr;
        logic [4:0] alu_fun;
        logic       alu_wf;
        logic [1:0] out_c;
        logic [1:0] out_d;
        logic [2:0] arf_fun;
        logic [2:0] arf_reg;
        logic       ir_lh;
        logic       ir_wr;
        logic       mem_wr;
        logic       mem_cs;
        logic       mux_c;
        logic [1:0] mux_a;
        logic [1:0] mux_b;
        logic       halted;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    alu_system_control_unit_if cu_bus ();

    alu_system_control_unit dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .cu_bus (cu_bus)
    );

    always #5 clk = ~clk;

    // Behavioural datapath: memory, IR, PC, R1..R4 and Z flag.
    logic [7:0]  mem [256];
    logic [15:0] dp_pc;
    logic [15:0] dp_ir;
    logic [3:0]  dp_flags;
    logic [15:0] dp_r [4];
    logic [15:0] init_r [4];
    logic [7:0]  dp_rd;
    logic [15:0] dp_opa;
    logic [15:0] dp_opb;
    logic [15:0] dp_alu;
    logic [15:0] dp_rf_in;
    vec_t        got;

    function automatic logic [15:0] alu(input logic [4:0] f, input logic [15:0] a,
                                        input logic [15:0] b);
        case (f[1:0])
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a ^ b;
        endcase
    endfunction

    assign cu_bus.IROut     = dp_ir;
    assign cu_bus.ALU_Flags = dp_flags;
    assign dp_rd    = (cu_bus.ARF_OutDSel == ArfOutPc) ? mem[dp_pc[7:0]] : 8'hEE;
    assign dp_opa   = cu_bus.RF_OutASel[2] ? 16'hDEAD : dp_r[cu_bus.RF_OutASel[1:0]];
    assign dp_opb   = cu_bus.RF_OutBSel[2] ? 16'hDEAD : dp_r[cu_bus.RF_OutBSel[1:0]];
    assign dp_alu   = alu(cu_bus.ALU_FunSel, dp_opa, dp_opb);
    assign dp_rf_in = (cu_bus.MuxASel == MuxAImm) ? {8'h00, dp_ir[7:0]} :
                      (cu_bus.MuxASel == MuxAAlu) ? dp_alu : 16'hDEAD;

    always @(posedge clk) begin
        if (rst) begin
            dp_pc    <= 16'hBEEF;
            dp_ir    <= 16'h0000;
            dp_flags <= 4'h0;
            for (int i = 0; i < 4; i++) dp_r[i] <= init_r[i];
        end else begin
            if (cu_bus.ARF_RegSel == ArfPc) begin
                case (cu_bus.ARF_FunSel)
                    FunClear: dp_pc <= 16'h0000;
                    FunInc:   dp_pc <= dp_pc + 16'd1;
                    FunLoad:  dp_pc <= {8'h00, (cu_bus.MuxBSel == MuxBImm) ? dp_ir[7:0] : 8'hEE};
                    default:  ;
                endcase
            end
            if (cu_bus.IR_Write && cu_bus.Mem_CS == MemCsEnable && cu_bus.Mem_WR == MemWrRead) begin
                if (cu_bus.IR_LH) dp_ir[15:8] <= dp_rd;
                else dp_ir[7:0] <= dp_rd;
            end
            if (cu_bus.RF_FunSel == FunLoad) begin
                for (int i = 0; i < 4; i++) if (cu_bus.RF_RegSel[3-i]) dp_r[i] <= dp_rf_in;
            end
            if (cu_bus.ALU_WF) dp_flags <= {dp_alu == 16'h0000, 3'b000};
        end
    end

    always_comb begin
        got         = '0;
        got.out_a   = cu_bus.RF_OutASel;
        got.out_b   = cu_bus.RF_OutBSel;
        got.rf_fun  = cu_bus.RF_FunSel;
        got.rf_reg  = cu_bus.RF_RegSel;
        got.rf_scr  = cu_bus.RF_ScrSel;
        got.alu_fun = cu_bus.ALU_FunSel;
        got.alu_wf  = cu_bus.ALU_WF;
        got.out_c   = cu_bus.ARF_OutCSel;
        got.out_d   = cu_bus.ARF_OutDSel;
        got.arf_fun = cu_bus.ARF_FunSel;
        got.arf_reg = cu_bus.ARF_RegSel;
        got.ir_lh   = cu_bus.IR_LH;
        got.ir_wr   = cu_bus.IR_Write;
        got.mem_wr  = cu_bus.Mem_WR;
        got.mem_cs  = cu_bus.Mem_CS;
        got.mux_c   = cu_bus.MuxCSel;
        got.mux_a   = cu_bus.MuxASel;
        got.mux_b   = cu_bus.MuxBSel;
        got.halted  = cu_bus.Halted;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic vec_t idle_v();
        vec_t v;
        v         = '0;
        v.rf_fun  = FunHold;
        v.rf_reg  = RfRegNone;
        v.rf_scr  = RfRegNone;
        v.arf_fun = FunHold;
        v.arf_reg = ArfRegNone;
        v.mem_wr  = MemWrRead;
        v.mem_cs  = MemCsDisable;
        return v;
    endfunction

    function automatic vec_t fetch_v(input logic lh);
        vec_t v;
        v         = idle_v();
        v.out_d   = ArfOutPc;
        v.mem_cs  = MemCsEnable;
        v.ir_wr   = 1'b1;
        v.ir_lh   = lh;
        v.arf_fun = FunInc;
        v.arf_reg = ArfPc;
        return v;
    endfunction

    function automatic logic jump_taken(input logic [15:0] ir, input logic z);
`ifdef CU_COND_JUMP_EN
        return !ir[13] || z;
`else
        return 1'b1;
`endif
    endfunction

    function automatic vec_t exec_v(input logic [15:0] ir, input logic z);
        vec_t v;
        v = idle_v();
        case (ir[15:14])
            2'b00: begin
                v.out_a   = {1'b0, ir[5:4]};
                v.out_b   = {1'b0, ir[3:2]};
                v.alu_fun = ir[13:9];
                v.alu_wf  = ir[8];
                v.mux_a   = MuxAAlu;
                v.rf_fun  = FunLoad;
                v.rf_reg  = RegR1 >> ir[7:6];
            end
            2'b01: begin
                v.mux_a  = MuxAImm;
                v.rf_fun = FunLoad;
                v.rf_reg = RegR1 >> ir[9:8];
            end
            default: begin
                if (jump_taken(ir, z)) begin
                    v.mux_b   = MuxBImm;
                    v.arf_fun = FunLoad;
                    v.arf_reg = ArfPc;
                end
            end
        endcase
        return v;
    endfunction

    function automatic logic [15:0] rand_instr();
        int unsigned c;
        logic [15:0] w;
        c = $urandom_range(0, 9);
        w = 16'($urandom);
        if (c < 4) w[15:14] = 2'b00;
        else if (c < 7) w[15:14] = 2'b01;
        else if (c < 9) begin
            w[15:14] = 2'b10;
            w[0]     = 1'b0;
        end else w[15:14] = 2'b11;
        return w;
    endfunction

    task automatic put(input int a, input logic [15:0] w);
        mem[a]     = w[7:0];
        mem[a + 1] = w[15:8];
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        check("reset_idle", 64'(got), 64'(idle_v()));
        rst = 1'b0;
    endtask

    // Runs from reset for at most `budget` instructions against the instruction-level model.
    task automatic run_prog(input int budget);
        logic [15:0] isa_pc;
        logic [15:0] isa_r [4];
        logic [15:0] ir;
        logic [15:0] res;
        logic        isa_z;
        logic        halted;
        vec_t        v;
        isa_pc = 16'h0000;
        isa_z  = 1'b0;
        halted = 1'b0;
        for (int i = 0; i < 4; i++) isa_r[i] = init_r[i];
        do_reset(3);
        @(negedge clk);
        v         = idle_v();
        v.arf_fun = FunClear;
        v.arf_reg = ArfPc;
        check("init", 64'(got), 64'(v));
        for (int k = 0; k < budget && !halted; k++) begin
            ir = {mem[8'(isa_pc + 16'd1)], mem[isa_pc[7:0]]};
            @(negedge clk);
            check($sformatf("pc@%h", isa_pc), 64'(dp_pc), 64'(isa_pc));
            for (int i = 0; i < 4; i++) check($sformatf("r%0d", i + 1), 64'(dp_r[i]), 64'(isa_r[i]));
            check("fetch_l", 64'(got), 64'(fetch_v(1'b0)));
            @(negedge clk);
            check("fetch_h", 64'(got), 64'(fetch_v(1'b1)));
            @(negedge clk);
            check("decode", 64'(got), 64'(idle_v()));
            check("ir", 64'(dp_ir), 64'(ir));
            if (ir[15:14] == 2'b11) begin
                halted = 1'b1;
                v      = idle_v();
                v.halted = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    check("halt", 64'(got), 64'(v));
                    check("halt_pc", 64'(dp_pc), 64'(isa_pc + 16'd2));
                end
            end else begin
                @(negedge clk);
                check($sformatf("exec_%h", ir), 64'(got), 64'(exec_v(ir, isa_z)));
                case (ir[15:14])
                    2'b00: begin
                        res = alu(ir[13:9], isa_r[ir[5:4]], isa_r[ir[3:2]]);
                        isa_r[ir[7:6]] = res;
                        if (ir[8]) isa_z = (res == 16'h0000);
                        isa_pc += 16'd2;
                    end
                    2'b01: begin
                        isa_r[ir[9:8]] = {8'h00, ir[7:0]};
                        isa_pc += 16'd2;
                    end
                    default: isa_pc = jump_taken(ir, isa_z) ? {8'h00, ir[7:0]} : isa_pc + 16'd2;
                endcase
            end
        end
        @(negedge clk);
        check("end_pc", 64'(dp_pc), 64'(halted ? isa_pc + 16'd2 : isa_pc));
        for (int i = 0; i < 4; i++) check($sformatf("end_r%0d", i + 1), 64'(dp_r[i]), 64'(isa_r[i]));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i += 2) put(i, rand_instr());
        for (int i = 0; i < 4; i++) init_r[i] = 16'($urandom);
        put(0, 16'h415A);
        put(2, 16'h4103);
        put(4, 16'h4204);
        put(6, 16'h0918);
        put(8, 16'h8020);
        put(32, 16'hA030);
        put(34, 16'h07C0);
        put(36, 16'hA030);
        put(48, 16'hC000);
        run_prog(20);
        // Restart, then leave the run in FETCH_H of the next instruction before resetting.
        run_prog(1);
        @(negedge clk);
        run_prog(3);
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < 256; i += 2) put(i, rand_instr());
            for (int i = 0; i < 4; i++) init_r[i] = 16'($urandom);
            run_prog(25);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
